// File: rtl/reg_alu_seq.sv
// reg_alu_seq: register file + ALU datapath core with a command handshake.
// Eight (2**ADDR_W) registers, two live combinational read ports, registered
// carry/zero/negative flags and a one-cycle "done" pulse per committed command.
// Optional build macro REG_ALU_SEQ_MUL_EN: when defined, op 111 is a multi-cycle
// shift-add multiply (IDLE -> MUL -> WB); when undefined, op 111 is a NOP that
// commits in one cycle without touching registers or flags.
module reg_alu_seq #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              sel,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  d_in,
    output logic [WIDTH-1:0]  d_out_a,
    output logic [WIDTH-1:0]  d_out_b,
    output logic              done,
    output logic              cout,
    output logic              zero,
    output logic              neg
);

    localparam int NREG = 1 << ADDR_W;

    logic [WIDTH-1:0]  regs [NREG];
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic              accept;
    logic              alu_cmd;
    logic              start_mul;
    logic [WIDTH-1:0]  alu_res;
    logic              alu_c;
    logic [WIDTH:0]    sum;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [WIDTH-1:0]  wdata;
    logic              mul_wb;
    logic [WIDTH-1:0]  mul_lo;
    logic              mul_ovf;
    logic [ADDR_W-1:0] mul_dst;

    // Operands and read ports are the same live register reads; no forwarding.
    assign op_a    = regs[rd_addr_a];
    assign op_b    = regs[rd_addr_b];
    assign d_out_a = op_a;
    assign d_out_b = op_b;

    assign accept  = cmd_valid & cmd_ready;
    // Single-cycle ALU commits: every op except 111 (MUL or NOP).
    assign alu_cmd = accept & sel & (op != 3'b111);

    // Combinational ALU for the single-cycle ops.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        sum     = '0;
        case (op)
            3'b000: begin
                sum     = {1'b0, op_a} + {1'b0, op_b};
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
            end
            3'b001: begin
                sum     = {1'b0, op_a} - {1'b0, op_b};
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
            end
            3'b010: alu_res = op_a & op_b;
            3'b011: alu_res = op_a | op_b;
            3'b100: alu_res = op_a ^ op_b;
            3'b101: begin
                alu_res = {op_a[WIDTH-2:0], 1'b0};
                alu_c   = op_a[WIDTH-1];
            end
            3'b110: begin
                alu_res = {1'b0, op_a[WIDTH-1:1]};
                alu_c   = op_a[0];
            end
            default: ;
        endcase
    end

`ifdef REG_ALU_SEQ_MUL_EN
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;
    localparam int         CNT_W  = $clog2(WIDTH);

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod;
    logic [ADDR_W-1:0]  dst;
    logic [WIDTH:0]     part;

    assign cmd_ready = (state == S_IDLE);
    assign start_mul = accept & sel & (op == 3'b111);
    assign mul_wb    = (state == S_WB);
    assign mul_lo    = prod[WIDTH-1:0];
    assign mul_ovf   = |prod[2*WIDTH-1:WIDTH];
    assign mul_dst   = dst;

    // Upper half plus the conditionally added multiplicand, carry kept.
    assign part = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? mcand : {WIDTH{1'b0}})};

    // Multiply sequencer: snapshot operands at accept, WIDTH shift-add steps, then write back.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            mcand <= '0;
            prod  <= '0;
            dst   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_mul) begin
                        state <= S_MUL;
                        cnt   <= '0;
                        mcand <= op_a;
                        prod  <= {{WIDTH{1'b0}}, op_b};
                        dst   <= wr_addr;
                    end
                end
                S_MUL: begin
                    prod <= {part, prod[WIDTH-1:1]};
                    cnt  <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= S_WB;
                    end
                end
                S_WB:    state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
`else
    assign cmd_ready = 1'b1;
    assign start_mul = 1'b0;
    assign mul_wb    = 1'b0;
    assign mul_lo    = '0;
    assign mul_ovf   = 1'b0;
    assign mul_dst   = '0;
`endif

    // Write-port select: product write-back, external load, or ALU result.
    always_comb begin
        we    = 1'b0;
        waddr = wr_addr;
        wdata = d_in;
        if (mul_wb) begin
            we    = 1'b1;
            waddr = mul_dst;
            wdata = mul_lo;
        end else if (accept && !sel) begin
            we = 1'b1;
        end else if (alu_cmd) begin
            we    = 1'b1;
            wdata = alu_res;
        end
    end

    // One storage register per address, each with its own write enable.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
            logic [WIDTH-1:0] q;
            // Register gi captures the write data when addressed.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    q <= '0;
                end else if (we && (waddr == ADDR_W'(gi))) begin
                    q <= wdata;
                end
            end
            assign regs[gi] = q;
        end
    endgenerate

    // Flags follow ALU commits and product write-back only; loads keep them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cout <= 1'b0;
            zero <= 1'b0;
            neg  <= 1'b0;
        end else if (mul_wb) begin
            cout <= mul_ovf;
            zero <= (mul_lo == '0);
            neg  <= mul_lo[WIDTH-1];
        end else if (alu_cmd) begin
            cout <= alu_c;
            zero <= (alu_res == '0);
            neg  <= alu_res[WIDTH-1];
        end
    end

    // Done pulses the cycle after any commit; a started multiply commits at write-back.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done <= 1'b0;
        end else begin
            done <= mul_wb | (accept & ~start_mul);
        end
    end

endmodule

// File: doc/reg_alu_seq.md
Name: reg_alu_seq

Overview:
Parametrised register-file/ALU datapath with a command handshake, 3-bit opcode, a registered flag set and an optional multi-cycle shift-add multiplier. Each accepted command either loads external data or writes an ALU result into one register. Two combinational read ports expose register contents at all times. The block is the datapath core for the small sequential CPU built on the existing 16-bit library cells.

Parameters:
WIDTH, 16, data and register width in bits (>=4)
ADDR_W, 3, register address width; register count = 2**ADDR_W

Ports:
clk  in  1  clock, rising-edge
reset  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command this cycle
sel  in  1  0 = load d_in into reg[wr_addr]; 1 = write ALU result into reg[wr_addr]
op  in  3  ALU opcode; ignored when sel=0
rd_addr_a  in  ADDR_W  read/operand-A address
rd_addr_b  in  ADDR_W  read/operand-B address
wr_addr  in  ADDR_W  destination register
d_in  in  WIDTH  load data
d_out_a  out  WIDTH  reg[rd_addr_a], combinational
d_out_b  out  WIDTH  reg[rd_addr_b], combinational
done  out  1  one-cycle pulse, command committed
cout  out  1  carry/borrow flag, registered
zero  out  1  result==0 flag, registered
neg  out  1  result MSB flag, registered

Behaviour:
- Reset (reset=0, async): all registers 0; cout, zero and neg 0; done 0; FSM to IDLE; cmd_ready 1. Any in-flight MUL is aborted with no write.
- Accept = cmd_valid & cmd_ready at a rising edge. All command fields are sampled only at accept.
- FSM states:
  - IDLE: cmd_ready=1.
  - MUL: cmd_ready=0; iterates.
  - WB: cmd_ready=0; writes the product.
  - Transitions: IDLE->MUL on accept with sel=1, op=111. MUL->WB after WIDTH iterations. WB->IDLE. All other accepts stay in IDLE.
- Single-cycle commands (load, op 000-110): reg[wr_addr] is written at the accept edge. done=1 for the following cycle. Back-to-back accepts are allowed every cycle.
- Ops use A=reg[rd_addr_a] and B=reg[rd_addr_b]:
  - 000 ADD: A+B; cout = carry out.
  - 001 SUB: A-B; cout = borrow (A<B unsigned).
  - 010 AND: cout=0.
  - 011 OR: cout=0.
  - 100 XOR: cout=0.
  - 101 SHL: A<<1; cout = A[MSB].
  - 110 SHR: A>>1 logical; cout = A[0].
  - 111 MUL: see Optional Feature.
- Flags: updated only on ALU commits (sel=1). zero = (result==0); neg = result[WIDTH-1]. Loads leave flags unchanged.
- Read ports are always live. A write is visible on d_out_a/d_out_b the cycle after the write edge; there is no same-cycle forwarding.
- rd_addr_a may equal rd_addr_b, and wr_addr may equal either. Operands are values before the write edge.
- MUL: A and B are snapshotted at accept. An iteration counter runs WIDTH cycles (shift-add, 2*WIDTH-bit accumulator). The WB edge writes the low WIDTH bits.
  - Flags at WB: cout = |high half (overflow); zero and neg come from the low half.
  - done is high in the cycle after the WB edge, i.e. WIDTH+2 cycles after the accept edge.
  - Register contents may change only via this command while busy (cmd_ready=0); read ports remain usable.
- cmd_valid while cmd_ready=0 is ignored (not queued).

Optional Feature:
REG_ALU_SEQ_MUL_EN
- Defined: op 111 is the multi-cycle multiply described above, with MUL and WB states present.
- Undefined: op 111 is NOP. It commits in one cycle with no register write and flags unchanged, and done still pulses. No multiplier logic or MUL/WB states are synthesised.

Test Plan:
- Load r1=0x1234, r2=0x00FF (sel=0), then ADD r3=r1+r2 -> r3=0x1333; cout=0, zero=0, neg=0; done pulses 1 cycle after each accept; flags unchanged after the loads.
- r4=0xFFFF, r5=0x0001, ADD r6=r4+r5 -> r6=0x0000, cout=1, zero=1. Then SHL r7=r4 -> 0xFFFE, cout=1, neg=1.
- r1=0x0005, r2=0x0007, SUB r3=r1-r2 -> r3=0xFFFE, cout=1, neg=1. Then SHR of 0x0005 -> 0x0002, cout=1.
- (MUL_EN, WIDTH=16) r1=0x0100, r2=0x0101, MUL r3 -> cmd_ready=0 for 17 cycles; cmd_valid held high meanwhile is ignored; r3=0x0100, cout=1; done exactly 18 cycles after accept.
- (MUL_EN) reset=0 asserted 5 cycles into MUL to r3 -> r3 and all registers 0, cmd_ready=1 after release, done never pulses.
- (no MUL_EN) op 111 with wr_addr=r3 holding 0x00AA -> r3 stays 0x00AA, flags unchanged, done pulses next cycle, cmd_ready stays 1.
